// File: rtl/system_pkg.sv
// Shared alarm-system types: system FSM states, entry FSM states, key indices and BCD limit.
package system_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_SET     = 2'd1,
    STATE_TRIGGER = 2'd2,
    STATE_ALERT   = 2'd3
  } fsm_state_t;

  typedef enum logic [1:0] {
    ENTRY_EMPTY   = 2'd0,
    ENTRY_COLLECT = 2'd1,
    ENTRY_DONE    = 2'd2
  } entry_state_t;

  localparam int KEY_ENTER = 0;
  localparam int KEY_CLEAR = 1;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Code entry is only meaningful while the system is waiting for, or reacting to, an alarm.
  function automatic logic entry_enabled(input fsm_state_t state);
    return (state == STATE_IDLE) || (state == STATE_TRIGGER) || (state == STATE_ALERT);
  endfunction

endpackage

// File: rtl/code_entry_input_if.sv
// Signal bundle between the system FSM side (master) and the code entry front end (slave).
interface code_entry_input_if #(
  parameter int CODE_DIGITS = 4
) ();
  import system_pkg::*;

  localparam int COUNT_W = $clog2(CODE_DIGITS + 1);

  fsm_state_t                 system_state;
  logic [3:0]                 sw;
  logic [1:0]                 key_n;
  logic [3:0]                 current_value;
  logic [4*CODE_DIGITS-1:0]   code;
  logic                       code_valid;
  logic [COUNT_W-1:0]         digit_count;
  logic                       entry_error;

  modport master (
    output system_state, sw, key_n,
    input  current_value, code, code_valid, digit_count, entry_error
  );

  modport slave (
    input  system_state, sw, key_n,
    output current_value, code, code_valid, digit_count, entry_error
  );

endinterface

// File: rtl/code_entry_input_debouncer.sv
// key_debouncer: 2-FF synchroniser plus stability counter for one active-low push-button.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // press is raised on the same edge the accepted level drops, so it fires once per physical press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= 2'b11;
      level_n <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync  <= {sync[0], raw_n};
      press <= 1'b0;
      if (sync[1] == level_n) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level_n <= sync[1];
        cnt     <= '0;
        press   <= level_n;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/code_entry_input.sv
// code_entry_input: debounced keypad front end assembling a BCD code for the system FSM.
// Optional inactivity timeout on partial entries is built when INPUT_TIMEOUT_EN is defined.
module code_entry_input
  import system_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = CLK_HZ / 100,
  parameter int CODE_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES  = CLK_HZ * 5
) (
  input logic             clk,
  input logic             rst,
  code_entry_input_if.slave bus
);

  localparam int CODE_W  = 4 * CODE_DIGITS;
  localparam int COUNT_W = $clog2(CODE_DIGITS + 1);
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(CODE_DIGITS - 1);

  entry_state_t       state_q, state_d;
  logic [3:0]         sw_meta, sw_sync;
  logic [1:0]         key_level_n, key_press;
  logic [CODE_W-1:0]  buffer_q, code_q;
  logic [CODE_W+3:0]  shifted;
  logic [COUNT_W-1:0] count_q;
  logic               error_q;
  logic               entry_en, digit_ok, clear_req, enter_req;
  logic               accept, reject, abort, last_digit, timeout_hit;
  logic               unused_levels;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= bus.sw;
      sw_sync <= sw_meta;
    end
  end

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk     (clk),
    .rst     (rst),
    .raw_n   (bus.key_n[KEY_ENTER]),
    .level_n (key_level_n[KEY_ENTER]),
    .press   (key_press[KEY_ENTER])
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk     (clk),
    .rst     (rst),
    .raw_n   (bus.key_n[KEY_CLEAR]),
    .level_n (key_level_n[KEY_CLEAR]),
    .press   (key_press[KEY_CLEAR])
  );

  // Only the press pulses drive the entry logic; held levels are not needed here.
  assign unused_levels = ^key_level_n;

  // Clear dominates enter; a press landing in the DONE cycle is dropped.
  assign entry_en   = entry_enabled(bus.system_state);
  assign digit_ok   = (sw_sync <= BCD_MAX);
  assign clear_req  = key_press[KEY_CLEAR];
  assign enter_req  = key_press[KEY_ENTER] && !clear_req;
  assign accept     = enter_req && entry_en && digit_ok && (state_q != ENTRY_DONE);
  assign reject     = enter_req && !(entry_en && digit_ok);
  assign abort      = clear_req || !entry_en || timeout_hit;
  assign last_digit = (count_q == LAST_COUNT);
  assign shifted    = {buffer_q, sw_sync};

`ifdef INPUT_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] timer_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else if (state_q != ENTRY_COLLECT || accept) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == ENTRY_COLLECT) && (timer_q == TMR_LAST);
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTRY_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ENTRY_EMPTY: begin
        if (!abort && accept) begin
          state_d = last_digit ? ENTRY_DONE : ENTRY_COLLECT;
        end
      end
      ENTRY_COLLECT: begin
        if (abort) begin
          state_d = ENTRY_EMPTY;
        end else if (accept && last_digit) begin
          state_d = ENTRY_DONE;
        end
      end
      ENTRY_DONE: state_d = ENTRY_EMPTY;
      default:    state_d = ENTRY_EMPTY;
    endcase
  end

  always_comb begin
    bus.code_valid = (state_q == ENTRY_DONE);
  end

  // code is loaded on the edge into DONE so it is already stable while code_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      buffer_q <= '0;
      count_q  <= '0;
      code_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      error_q <= reject || timeout_hit;
      if (abort) begin
        buffer_q <= '0;
        count_q  <= '0;
      end else if (accept) begin
        if (last_digit) begin
          code_q   <= shifted[CODE_W-1:0];
          buffer_q <= '0;
          count_q  <= '0;
        end else begin
          buffer_q <= shifted[CODE_W-1:0];
          count_q  <= count_q + 1'b1;
        end
      end
    end
  end

  assign bus.current_value = sw_sync;
  assign bus.code          = code_q;
  assign bus.digit_count   = count_q;
  assign bus.entry_error   = error_q;

endmodule

// File: tb/tb_code_entry_input.sv
// Self-checking bench for code_entry_input against a queue-based model of code assembly.
// Define INPUT_TIMEOUT_EN for both bench and RTL to exercise the inactivity timeout.
`timescale 1ns/1ps
module tb_code_entry_input;
  import system_pkg::*;

  localparam int DEB = 8;
  localparam int CD  = 4;
  localparam int TMO = 64;
  // 2 sync edges + DEB counting edges give the press; the digit registers one edge later.
  localparam int PRESS_LAT = DEB + 3;

  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   failures;

  int              model_digits[$];
  logic [4*CD-1:0] exp_code;

  int              obs_cnt_cycle, obs_valid_cycle, obs_valid_cnt, obs_err_cycle, obs_err_cnt;
  logic [4*CD-1:0] obs_code;
  logic [2:0]      obs_final_count;

  always #5 clk = ~clk;

  code_entry_input_if #(.CODE_DIGITS(CD)) bus ();

  code_entry_input #(
    .CLK_HZ          (50_000_000),
    .DEBOUNCE_CYCLES (DEB),
    .CODE_DIGITS     (CD),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [4*CD-1:0] pack_code(input int q[$]);
    logic [4*CD-1:0] c;
    c = '0;
    foreach (q[i]) c = (c << 4) | (4*CD)'(q[i]);
    return c;
  endfunction

  // Press the selected keys for 30 cycles then release, recording what the outputs do.
  task automatic do_press(input logic [3:0] digit, input logic enter, input logic clear);
    logic [2:0] start_count;
    bus.sw = digit;
    repeat (4) @(negedge clk);
    start_count     = bus.digit_count;
    obs_cnt_cycle   = 0;
    obs_valid_cycle = 0;
    obs_valid_cnt   = 0;
    obs_err_cycle   = 0;
    obs_err_cnt     = 0;
    obs_code        = '0;
    bus.key_n = {~clear, ~enter};
    for (int i = 1; i <= 44; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.code_valid === 1'b1) begin
        obs_valid_cnt++;
        if (obs_valid_cycle == 0) begin
          obs_valid_cycle = i;
          obs_code        = bus.code;
        end
      end
      if (bus.entry_error === 1'b1) begin
        obs_err_cnt++;
        if (obs_err_cycle == 0) obs_err_cycle = i;
      end
      if (obs_cnt_cycle == 0 && bus.digit_count !== start_count) obs_cnt_cycle = i;
      if (i == 30) bus.key_n = 2'b11;
    end
    obs_final_count = bus.digit_count;
  endtask

  task automatic test_reset();
    logic [3:0] d;
    d = 4'($urandom_range(1, 15));
    rst = 1'b1;
    bus.sw = d;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.current_value !== 4'd0 || bus.code !== '0 || bus.code_valid !== 1'b0 ||
        bus.digit_count !== 3'd0 || bus.entry_error !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: cv=%h code=%h valid=%b count=%0d err=%b expected all 0",
               bus.current_value, bus.code, bus.code_valid, bus.digit_count, bus.entry_error);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.current_value !== 4'd0) begin
      failures++;
      $display("[TB] FAIL sync_lag_1: current_value=%h expected 0", bus.current_value);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.current_value !== d) begin
      failures++;
      $display("[TB] FAIL sync_lag_2: current_value=%h expected %h", bus.current_value, d);
    end
    model_digits.delete();
    exp_code = '0;
  endtask

  task automatic test_bounce();
    int first_e, changes, errs;
    logic [2:0] prev;
    bus.system_state = STATE_IDLE;
    bus.sw = 4'd1;
    repeat (4) @(negedge clk);
    prev = bus.digit_count;
    first_e = 0; changes = 0; errs = 0;
    for (int t = 0; t < 60; t++) begin
      if (t % 3 == 0 && t <= 18) bus.key_n[0] = ~bus.key_n[0];
      @(posedge clk); @(negedge clk);
      if (bus.entry_error === 1'b1) errs++;
      if (bus.digit_count !== prev) begin
        changes++;
        if (first_e == 0) first_e = t - 17;
      end
      prev = bus.digit_count;
      if (t == 45) bus.key_n[0] = 1'b1;
    end
    model_digits.push_back(1);
    checks++;
    if (first_e != PRESS_LAT) begin
      failures++;
      $display("[TB] FAIL bounce_latency: edges=%0d expected %0d", first_e, PRESS_LAT);
    end
    checks++;
    if (changes != 1 || bus.digit_count !== 3'd1 || errs != 0) begin
      failures++;
      $display("[TB] FAIL bounce_single_press: changes=%0d count=%0d errs=%0d expected 1/1/0",
               changes, bus.digit_count, errs);
    end
    do_press(4'd0, 1'b0, 1'b1);
    model_digits.delete();
    checks++;
    if (obs_final_count !== 3'd0 || obs_err_cnt != 0) begin
      failures++;
      $display("[TB] FAIL clear_only: count=%0d errs=%0d expected 0/0", obs_final_count, obs_err_cnt);
    end
  endtask

  task automatic test_code_entry();
    int digits[$];
    digits = '{1, 2, 3, 4};
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < CD; j++) digits.push_back($urandom_range(0, 9));
    foreach (digits[n]) begin
      case ($urandom_range(0, 2))
        0:       bus.system_state = STATE_IDLE;
        1:       bus.system_state = STATE_TRIGGER;
        default: bus.system_state = STATE_ALERT;
      endcase
      if (n < CD) bus.system_state = STATE_IDLE;
      do_press(4'(digits[n]), 1'b1, 1'b0);
      model_digits.push_back(digits[n]);
      if (model_digits.size() == CD) begin
        exp_code = pack_code(model_digits);
        model_digits.delete();
        checks++;
        if (obs_valid_cycle != PRESS_LAT || obs_valid_cnt != 1) begin
          failures++;
          $display("[TB] FAIL valid_strobe: cycle=%0d pulses=%0d expected %0d/1",
                   obs_valid_cycle, obs_valid_cnt, PRESS_LAT);
        end
        checks++;
        if (obs_code !== exp_code || bus.code !== exp_code) begin
          failures++;
          $display("[TB] FAIL code_value: strobe=%h held=%h expected %h", obs_code, bus.code, exp_code);
        end
      end else begin
        checks++;
        if (obs_cnt_cycle != PRESS_LAT || obs_valid_cnt != 0) begin
          failures++;
          $display("[TB] FAIL digit_latency: cycle=%0d valid=%0d expected %0d/0",
                   obs_cnt_cycle, obs_valid_cnt, PRESS_LAT);
        end
      end
      checks++;
      if (obs_final_count !== 3'(model_digits.size()) || obs_err_cnt != 0) begin
        failures++;
        $display("[TB] FAIL digit_count: got %0d errs=%0d expected %0d/0",
                 obs_final_count, obs_err_cnt, model_digits.size());
      end
    end
  endtask

  task automatic test_bad_digit();
    logic [3:0] d;
    bus.system_state = STATE_IDLE;
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? 4'hB : 4'($urandom_range(10, 15));
      do_press(d, 1'b1, 1'b0);
      checks++;
      if (obs_err_cycle != PRESS_LAT || obs_err_cnt != 1) begin
        failures++;
        $display("[TB] FAIL bad_digit_error: cycle=%0d pulses=%0d expected %0d/1",
                 obs_err_cycle, obs_err_cnt, PRESS_LAT);
      end
      checks++;
      if (obs_final_count !== 3'd0 || bus.code !== exp_code || obs_valid_cnt != 0) begin
        failures++;
        $display("[TB] FAIL bad_digit_state: count=%0d code=%h valid=%0d expected 0/%h/0",
                 obs_final_count, bus.code, obs_valid_cnt, exp_code);
      end
    end
  endtask

  task automatic test_enter_clear();
    bus.system_state = STATE_TRIGGER;
    do_press(4'd5, 1'b1, 1'b0);
    do_press(4'd6, 1'b1, 1'b0);
    checks++;
    if (obs_final_count !== 3'd2) begin
      failures++;
      $display("[TB] FAIL partial_count: got %0d expected 2", obs_final_count);
    end
    do_press(4'($urandom_range(0, 9)), 1'b1, 1'b1);
    model_digits.delete();
    checks++;
    if (obs_final_count !== 3'd0 || obs_err_cnt != 0 || obs_valid_cnt != 0 || bus.code !== exp_code) begin
      failures++;
      $display("[TB] FAIL enter_and_clear: count=%0d errs=%0d valid=%0d code=%h expected 0/0/0/%h",
               obs_final_count, obs_err_cnt, obs_valid_cnt, bus.code, exp_code);
    end
  endtask

  task automatic test_state_abort();
    bus.system_state = STATE_IDLE;
    do_press(4'd7, 1'b1, 1'b0);
    checks++;
    if (obs_final_count !== 3'd1) begin
      failures++;
      $display("[TB] FAIL abort_setup: count=%0d expected 1", obs_final_count);
    end
    bus.system_state = STATE_SET;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.digit_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL abort_count: got %0d expected 0", bus.digit_count);
    end
    do_press(4'd3, 1'b1, 1'b0);
    checks++;
    if (obs_err_cycle != PRESS_LAT || obs_err_cnt != 1 || obs_final_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL disabled_enter: cycle=%0d pulses=%0d count=%0d expected %0d/1/0",
               obs_err_cycle, obs_err_cnt, obs_final_count, PRESS_LAT);
    end
    checks++;
    if (bus.current_value !== 4'd3) begin
      failures++;
      $display("[TB] FAIL value_in_set: current_value=%h expected 3", bus.current_value);
    end
    model_digits.delete();
    bus.system_state = STATE_ALERT;
  endtask

  task automatic test_back_to_back();
    int op, exp_err, exp_valid;
    logic [3:0] d;
    for (int n = 0; n < 20; n++) begin
      op = $urandom_range(0, 9);
      exp_err = 0;
      exp_valid = 0;
      case ($urandom_range(0, 2))
        0:       bus.system_state = STATE_IDLE;
        1:       bus.system_state = STATE_TRIGGER;
        default: bus.system_state = STATE_ALERT;
      endcase
      if (op < 6) begin
        d = 4'($urandom_range(0, 9));
        do_press(d, 1'b1, 1'b0);
        model_digits.push_back(int'(d));
        if (model_digits.size() == CD) begin
          exp_code = pack_code(model_digits);
          model_digits.delete();
          exp_valid = 1;
        end
      end else if (op < 8 && model_digits.size() == 0) begin
        do_press(4'($urandom_range(10, 15)), 1'b1, 1'b0);
        exp_err = 1;
      end else if (op < 8) begin
        do_press(4'($urandom_range(0, 15)), 1'b0, 1'b1);
        model_digits.delete();
      end else begin
        bus.system_state = STATE_SET;
        do_press(4'($urandom_range(0, 9)), 1'b1, 1'b0);
        model_digits.delete();
        exp_err = 1;
      end
      checks++;
      if (obs_final_count !== 3'(model_digits.size())) begin
        failures++;
        $display("[TB] FAIL b2b_count op%0d: got %0d expected %0d", n, obs_final_count, model_digits.size());
      end
      checks++;
      if (obs_err_cnt != exp_err) begin
        failures++;
        $display("[TB] FAIL b2b_error op%0d: pulses=%0d expected %0d", n, obs_err_cnt, exp_err);
      end
      checks++;
      if (obs_valid_cnt != exp_valid) begin
        failures++;
        $display("[TB] FAIL b2b_valid op%0d: pulses=%0d expected %0d", n, obs_valid_cnt, exp_valid);
      end
      checks++;
      if (bus.code !== exp_code) begin
        failures++;
        $display("[TB] FAIL b2b_code op%0d: got %h expected %h", n, bus.code, exp_code);
      end
    end
    bus.system_state = STATE_IDLE;
  endtask

  task automatic test_reset_mid_entry();
    bus.system_state = STATE_IDLE;
    do_press(4'd0, 1'b0, 1'b1);
    model_digits.delete();
    do_press(4'd8, 1'b1, 1'b0);
    do_press(4'd2, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_code = '0;
    checks++;
    if (bus.code !== exp_code || bus.digit_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_entry: code=%h count=%0d expected 0/0", bus.code, bus.digit_count);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    int up_cycle, down_cycle, errs, err_cycle;
    bus.system_state = STATE_IDLE;
    bus.sw = 4'd9;
    repeat (4) @(negedge clk);
    up_cycle = 0; down_cycle = 0; errs = 0; err_cycle = 0;
    bus.key_n = 2'b10;
    for (int i = 1; i <= 120; i++) begin
      @(posedge clk); @(negedge clk);
      if (up_cycle == 0 && bus.digit_count === 3'd1) up_cycle = i;
      if (up_cycle != 0 && down_cycle == 0 && bus.digit_count === 3'd0) down_cycle = i;
      if (bus.entry_error === 1'b1) begin
        errs++;
        if (err_cycle == 0) err_cycle = i;
      end
      if (i == 30) bus.key_n = 2'b11;
    end
    checks++;
    if (up_cycle != PRESS_LAT) begin
      failures++;
      $display("[TB] FAIL timeout_setup: count rose at %0d expected %0d", up_cycle, PRESS_LAT);
    end
`ifdef INPUT_TIMEOUT_EN
    checks++;
    if (down_cycle != PRESS_LAT + TMO || bus.digit_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL timeout_clear: cleared at %0d count=%0d expected %0d/0",
               down_cycle, bus.digit_count, PRESS_LAT + TMO);
    end
    checks++;
    if (errs != 1 || err_cycle != PRESS_LAT + TMO) begin
      failures++;
      $display("[TB] FAIL timeout_error: pulses=%0d at %0d expected 1 at %0d", errs, err_cycle, PRESS_LAT + TMO);
    end
`else
    checks++;
    if (down_cycle != 0 || bus.digit_count !== 3'd1) begin
      failures++;
      $display("[TB] FAIL no_timeout_hold: cleared at %0d count=%0d expected never/1", down_cycle, bus.digit_count);
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("[TB] FAIL no_timeout_error: pulses=%0d expected 0", errs);
    end
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.system_state = STATE_IDLE;
    bus.sw = 4'd0;
    bus.key_n = 2'b11;
    exp_code = '0;
    test_reset();
    test_bounce();
    test_code_entry();
    test_bad_digit();
    test_enter_clear();
    test_state_abort();
    test_back_to_back();
    test_reset_mid_entry();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
